// File: rtl/uart_rx_if.sv
// Register-side and line-side signals of the UART receiver.
// Define UART_RX_PARITY_EN to add the parity_err_o flag.
interface uart_rx_if;
  logic       uart_rx_i;
  logic       rd_ack_i;
  logic [7:0] rcvd_byte_o;
  logic       rx_valid_o;
  logic       overrun_o;
  logic       frame_err_o;
  logic       busy_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  modport master (
    output uart_rx_i, rd_ack_i,
    input  rcvd_byte_o, rx_valid_o, overrun_o, frame_err_o, busy_o
`ifdef UART_RX_PARITY_EN
    , parity_err_o
`endif
  );

  modport slave (
    input  uart_rx_i, rd_ack_i,
    output rcvd_byte_o, rx_valid_o, overrun_o, frame_err_o, busy_o
`ifdef UART_RX_PARITY_EN
    , parity_err_o
`endif
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with single-byte holding register and sticky error flags.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop (8E1).
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic     clk_i,
  input  logic     rst_i,
  uart_rx_if.slave bus
);

  // CLKS_PER_BIT must be at least 4 for the half-bit start check to work.
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitEnd   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd  = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StStop, StWaitHigh
`ifdef UART_RX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            ferr_q, ferr_d;
  logic            perr_q, perr_d;
  logic            rx_s, tick, load, ferr_set, perr_set;

  assign rx_s = sync_q[1];
  assign tick = (cnt_q == BitEnd);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.uart_rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    load     = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfEnd) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (tick) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          cnt_d    = '0;
          perr_set = (rx_s != ^shift_q);
          state_d  = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          cnt_d = '0;
          if (rx_s) begin
            load    = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_set = 1'b1;
            state_d  = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Hold off while the line stays low so a break cannot look like a start bit.
      StWaitHigh: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Set conditions take priority over the read-acknowledge clear.
  always_comb begin
    byte_d  = load ? shift_q : byte_q;
    valid_d = (valid_q && !bus.rd_ack_i) || load;
    ovr_d   = (ovr_q && !bus.rd_ack_i) || (load && valid_q && !bus.rd_ack_i);
    ferr_d  = (ferr_q && !bus.rd_ack_i) || ferr_set;
    perr_d  = (perr_q && !bus.rd_ack_i) || perr_set;
  end

  assign bus.rcvd_byte_o = byte_q;
  assign bus.rx_valid_o  = valid_q;
  assign bus.overrun_o   = ovr_q;
  assign bus.frame_err_o = ferr_q;
  assign bus.busy_o      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;
  localparam int unsigned ClkFreq = 921600;
  localparam int unsigned Baud    = 115200;
  localparam int          Cpb     = 8;
`ifdef UART_RX_PARITY_EN
  localparam int          Nb      = 10;
`else
  localparam int          Nb      = 9;
`endif
  // Negedge index whose following posedge is the mid-stop-bit sample.
  localparam int          AckAt   = 6 + Cpb * Nb;
  localparam int          LatMin  = 2 + Cpb / 2 + Cpb * Nb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(ClkFreq), .BAUD(Baud)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;
  int fcnt = 0;
  int ack_target = -1;

  // Frame-level reference state.
  logic [7:0] m_byte;
  bit m_valid, m_ovr, m_ferr, m_perr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid_o === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    prev_valid = bus.rx_valid_o;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void m_reset();
    m_byte = 8'h00; m_valid = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
  endfunction

  function automatic void m_ack();
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
  endfunction

  // Effect of one complete frame; acked means rd_ack coincided with the stop sample.
  function automatic void m_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                                  input bit acked);
`ifdef UART_RX_PARITY_EN
    if (!par_ok) m_perr = 1;
`endif
    if (acked) m_ack();
    if (stop_ok) begin
      if (m_valid) m_ovr = 1;
      m_byte  = b;
      m_valid = 1;
    end else begin
      m_ferr = 1;
    end
  endfunction

  task automatic drive_bit(input logic v);
    bus.uart_rx_i = v;
    repeat (Cpb) begin
      @(negedge clk);
      fcnt++;
      bus.rd_ack_i = (fcnt == ack_target);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_ok,
                            input int ack_at);
    fcnt = 0;
    ack_target = ack_at;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ !par_ok);
`endif
    drive_bit(stop_bit);
    bus.uart_rx_i = 1'b1;
    bus.rd_ack_i  = 1'b0;
    ack_target = -1;
  endtask

  task automatic idle(input int n);
    bus.uart_rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    bus.rd_ack_i = 1'b1;
    @(negedge clk);
    bus.rd_ack_i = 1'b0;
    m_ack();
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    bus.uart_rx_i = 1'b1;
    bus.rd_ack_i  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    obs = {bus.rcvd_byte_o, bus.rx_valid_o, bus.overrun_o, bus.frame_err_o, bus.busy_o};
    total++;
    if (obs !== 12'h000) begin
      bad++; $display("FAIL reset_outputs got %h want 000", obs);
    end
  endtask

  task automatic test_single();
    int t0;
    rise_cyc = -1;
    t0 = cyc;
    send_frame(8'h55, 1'b1, 1'b1, -1);
    m_frame(8'h55, 1, 1, 0);
    idle(4);
    total++;
    if (bus.rcvd_byte_o !== m_byte) begin
      bad++; $display("FAIL single_byte got %h want %h", bus.rcvd_byte_o, m_byte);
    end
    total++;
    if ({bus.rx_valid_o, bus.overrun_o, bus.frame_err_o, bus.busy_o} !== {m_valid, m_ovr, m_ferr, 1'b0}) begin
      bad++; $display("FAIL single_flags got %b want %b",
                      {bus.rx_valid_o, bus.overrun_o, bus.frame_err_o, bus.busy_o},
                      {m_valid, m_ovr, m_ferr, 1'b0});
    end
    total++;
    if (rise_cyc < 0 || rise_cyc - t0 < LatMin || rise_cyc - t0 > LatMin + 1) begin
      bad++; $display("FAIL single_latency got %0d want %0d..%0d", rise_cyc - t0, LatMin, LatMin + 1);
    end
    pulse_ack();
    total++;
    if (bus.rx_valid_o !== 1'b0) begin
      bad++; $display("FAIL ack_clears_valid got %b want 0", bus.rx_valid_o);
    end
    total++;
    if (bus.rcvd_byte_o !== 8'h55) begin
      bad++; $display("FAIL ack_keeps_byte got %h want 55", bus.rcvd_byte_o);
    end
  endtask

  task automatic test_glitch();
    bit seen_busy = 0;
    bus.uart_rx_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.uart_rx_i = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy_o === 1'b1) seen_busy = 1;
    end
    total++;
    if (!seen_busy) begin
      bad++; $display("FAIL glitch_busy_pulse got 0 want 1");
    end
    total++;
    if ({bus.rx_valid_o, bus.overrun_o, bus.frame_err_o, bus.busy_o} !== 4'b0000) begin
      bad++; $display("FAIL glitch_idle got %b want 0000",
                      {bus.rx_valid_o, bus.overrun_o, bus.frame_err_o, bus.busy_o});
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    m_frame(8'hA5, 1, 1, 0);
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    m_frame(8'h3C, 1, 1, 0);
    idle(4);
    total++;
    if ({bus.rcvd_byte_o, bus.rx_valid_o, bus.overrun_o} !== {m_byte, m_valid, m_ovr}) begin
      bad++; $display("FAIL b2b_overrun got %h/%b%b want %h/%b%b", bus.rcvd_byte_o,
                      bus.rx_valid_o, bus.overrun_o, m_byte, m_valid, m_ovr);
    end
    pulse_ack();
    total++;
    if ({bus.rx_valid_o, bus.overrun_o, bus.frame_err_o} !== 3'b000) begin
      bad++; $display("FAIL b2b_ack_clear got %b want 000",
                      {bus.rx_valid_o, bus.overrun_o, bus.frame_err_o});
    end
  endtask

  task automatic test_break();
    bus.uart_rx_i = 1'b0;
    repeat (20 * Cpb) @(negedge clk);
    m_frame(8'h00, 0, 1, 0);
    total++;
    if ({bus.frame_err_o, bus.rx_valid_o, bus.busy_o} !== {m_ferr, m_valid, 1'b1}) begin
      bad++; $display("FAIL break_hold got %b want %b",
                      {bus.frame_err_o, bus.rx_valid_o, bus.busy_o}, {m_ferr, m_valid, 1'b1});
    end
    idle(4);
    total++;
    if (bus.busy_o !== 1'b0) begin
      bad++; $display("FAIL break_release got %b want 0", bus.busy_o);
    end
    send_frame(8'h81, 1'b1, 1'b1, -1);
    m_frame(8'h81, 1, 1, 0);
    idle(4);
    total++;
    if ({bus.rcvd_byte_o, bus.rx_valid_o, bus.frame_err_o} !== {m_byte, m_valid, m_ferr}) begin
      bad++; $display("FAIL break_next_frame got %h/%b%b want %h/%b%b", bus.rcvd_byte_o,
                      bus.rx_valid_o, bus.frame_err_o, m_byte, m_valid, m_ferr);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] obs;
    fcnt = 0;
    ack_target = -1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    bus.uart_rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    obs = {bus.rcvd_byte_o, bus.rx_valid_o, bus.overrun_o, bus.frame_err_o, bus.busy_o};
    total++;
    if (obs !== 12'h000) begin
      bad++; $display("FAIL midframe_reset got %h want 000", obs);
    end
    idle(2 * Cpb);
    send_frame(8'h12, 1'b1, 1'b1, -1);
    m_frame(8'h12, 1, 1, 0);
    idle(4);
    total++;
    if ({bus.rcvd_byte_o, bus.rx_valid_o, bus.overrun_o, bus.frame_err_o} !==
        {m_byte, m_valid, m_ovr, m_ferr}) begin
      bad++; $display("FAIL after_reset_frame got %h/%b%b%b want %h/%b%b%b", bus.rcvd_byte_o,
                      bus.rx_valid_o, bus.overrun_o, bus.frame_err_o,
                      m_byte, m_valid, m_ovr, m_ferr);
    end
  endtask

  task automatic test_ack_with_load();
    logic [7:0] b;
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b1, AckAt);
    m_frame(b, 1, 1, 1);
    idle(4);
    total++;
    if ({bus.rcvd_byte_o, bus.rx_valid_o, bus.overrun_o} !== {m_byte, m_valid, m_ovr}) begin
      bad++; $display("FAIL ack_with_load got %h/%b%b want %h/%b%b", bus.rcvd_byte_o,
                      bus.rx_valid_o, bus.overrun_o, m_byte, m_valid, m_ovr);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit stop_ok, par_ok;
    int mode;
    for (int n = 0; n < 12; n++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      par_ok  = ($urandom_range(0, 3) != 0);
`else
      par_ok  = 1;
`endif
      mode = $urandom_range(0, 2);
      if (mode == 1) pulse_ack();
      send_frame(b, stop_ok, par_ok, (mode == 2) ? AckAt : -1);
      m_frame(b, stop_ok, par_ok, mode == 2);
      idle(4);
      total++;
      if ({bus.rcvd_byte_o, bus.rx_valid_o, bus.overrun_o, bus.frame_err_o, bus.busy_o} !==
          {m_byte, m_valid, m_ovr, m_ferr, 1'b0}) begin
        bad++; $display("FAIL random_%0d got %h/%b%b%b%b want %h/%b%b%b0", n, bus.rcvd_byte_o,
                        bus.rx_valid_o, bus.overrun_o, bus.frame_err_o, bus.busy_o,
                        m_byte, m_valid, m_ovr, m_ferr);
      end
`ifdef UART_RX_PARITY_EN
      total++;
      if (bus.parity_err_o !== m_perr) begin
        bad++; $display("FAIL random_parity_%0d got %b want %b", n, bus.parity_err_o, m_perr);
      end
`endif
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    pulse_ack();
    send_frame(8'h07, 1'b1, 1'b0, -1);
    m_frame(8'h07, 1, 0, 0);
    idle(4);
    total++;
    if ({bus.parity_err_o, bus.rcvd_byte_o} !== {m_perr, m_byte}) begin
      bad++; $display("FAIL parity_bad got %b/%h want %b/%h", bus.parity_err_o,
                      bus.rcvd_byte_o, m_perr, m_byte);
    end
    pulse_ack();
    send_frame(8'h07, 1'b1, 1'b1, -1);
    m_frame(8'h07, 1, 1, 0);
    idle(4);
    total++;
    if ({bus.parity_err_o, bus.rx_valid_o} !== {m_perr, m_valid}) begin
      bad++; $display("FAIL parity_good got %b%b want %b%b", bus.parity_err_o,
                      bus.rx_valid_o, m_perr, m_valid);
    end
  endtask
`endif

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_glitch();
    test_back_to_back();
    test_break();
    test_reset_mid();
    test_ack_with_load();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the SoC serial input; drives the currently tied-off uart_rcvd_byte and uart_status register fields in the regfile.
- Complements the transmit path, where core writes to register address 0, byte lane 1, send characters.
- Frame format: 8N1, LSB first. Fixed integer clocks-per-bit timing. Single-byte holding register with sticky error flags, cleared by a read-acknowledge strobe from the register interface.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. Localparam CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, must be >= 4). Counter width = $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- uart_rx  input  1  asynchronous serial line, idle high.
- rd_ack  input  1  one-cycle pulse: software has read rcvd_byte; clears rx_valid, overrun, frame_err.
- rcvd_byte  output  8  last received byte.
- rx_valid  output  1  rcvd_byte holds an unread byte.
- overrun  output  1  sticky: a byte was overwritten before rd_ack.
- frame_err  output  1  sticky: stop bit sampled low.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst=1 at posedge clk): all outputs 0. Synchronizer flops = 1. FSM = IDLE. Counters = 0. Reset mid-frame abandons the frame with no partial load.
- Input sync: uart_rx passes through 2 flops giving rx_s. All decisions use rx_s, adding 2 cycles of latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START, cnt=0.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit). If rx_s==0 -> DATA, cnt=0, bit_idx=0. If rx_s==1 -> IDLE (glitch rejected, no flags).
  - DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first), cnt=0, bit_idx++. After bit_idx 7 -> STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample the stop bit.
    - Stop bit 1: load rcvd_byte<=shift, rx_valid<=1 -> IDLE.
    - Stop bit 0: frame_err<=1, no load -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then -> IDLE. Prevents a break condition from re-triggering a start.
- Latency: rx_valid rises on the cycle after the mid-stop-bit sample, i.e. 2 sync cycles + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the uart_rx falling edge, within +1 cycle.
- Overrun: a load while rx_valid==1 and rd_ack==0 sets overrun=1. The new byte replaces rcvd_byte.
- rd_ack alone: clears rx_valid, overrun and frame_err on the next edge.
- rd_ack in the same cycle as a load: the load wins. rx_valid stays 1 with the new byte; overrun and frame_err are cleared; no overrun is flagged.
- Frame_err set in the same cycle as rd_ack: frame_err ends at 1.
- rcvd_byte is unchanged by rd_ack.
- busy = (state != IDLE).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled at CLKS_PER_BIT-1 like a data bit. Even parity.
  - Adds output parity_err (1 bit, sticky, reset 0, cleared by rd_ack like frame_err).
  - On mismatch, parity_err<=1; the byte is still loaded if the stop bit is good.
  - Frame length is 11 bit periods.
- Undefined: no PARITY state, no parity_err port, 8N1 only.

Test Plan:
All tests use CLK_FREQ=921600, BAUD=115200 (CLKS_PER_BIT=8).
- Drive 8N1 frame 0x55, then idle -> rcvd_byte=0x55, rx_valid=1, overrun=0, frame_err=0, busy=0 afterwards. Pulse rd_ack -> rx_valid=0 next cycle, rcvd_byte stays 0x55.
- Low glitch of 2 clk on idle line -> busy pulses, returns to IDLE, rx_valid=0, no flags.
- Frames 0xA5 then 0x3C back-to-back, no rd_ack -> rcvd_byte=0x3C, rx_valid=1, overrun=1. One rd_ack -> all flags 0.
- Hold uart_rx low for 20 bit times, then high -> frame_err=1, rx_valid=0, FSM in WAIT_HIGH until line high. Following frame 0x81 -> rcvd_byte=0x81, rx_valid=1, frame_err still 1.
- Assert rst for 1 cycle at bit 4 of frame 0xFF, then send 0x12 -> all outputs 0 after reset, then rcvd_byte=0x12, rx_valid=1, no errors.
- UART_RX_PARITY_EN defined: 0x07 with parity bit 0 -> parity_err=1, rcvd_byte=0x07. 0x07 with parity bit 1 after rd_ack -> parity_err=0.
